// File: rtl/dom_rnd_pkg.sv
// Shared constants and helpers for the DOM fresh-randomness source.
// Also used by the gadget wrapper to size its random input.
package dom_rnd_pkg;

  localparam int LFSR_W = 32;
  // Taps for x^32+x^22+x^2+x+1: state bits 31, 21, 1, 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [0:0] ST_UNSEEDED = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  // One Fibonacci shift: feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s
  );
    logic nb;
    nb = ^(s & LFSR_TAPS);
    return {s[LFSR_W-2:0], nb};
  endfunction

  // Fresh bits the DOM AND gadget needs per cycle.
  function automatic int n_rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

endpackage

// File: rtl/dom_rnd_lfsr_core.sv
// LFSR state register with seed load and an N_RND-step unroll.
// Load has priority over advance.
module dom_rnd_lfsr_core
  import dom_rnd_pkg::*;
#(
  parameter int N_RND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state,
  output logic [N_RND-1:0]  rnd
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next state: seed load, N_RND chained steps, or hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (adv) begin
      for (int i = 0; i < N_RND; i++) begin
        state_d = lfsr_step(state_d);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign state = state_q;
  assign rnd   = state_q[N_RND-1:0];

endmodule

// File: rtl/dom_rnd_prng.sv
// Fresh-randomness source for the DOM AND gadget: seed handshake,
// run/unseeded control, consumption counter and reseed request.
module dom_rnd_prng
  import dom_rnd_pkg::*;
#(
  parameter  int d             = 2,
  parameter  int RESEED_PERIOD = 1024,
  localparam int N_RND         = n_rnd(d)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              en,
  output logic [N_RND-1:0]  rnd,
  output logic              rnd_valid,
  output logic              reseed_req,
  output logic              seed_err
);

  localparam int CNT_W = $clog2(RESEED_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_PERIOD);

  logic [0:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept, load, adv;
  logic [LFSR_W-1:0] state;

  assign seed_ready = ~rst;
  assign accept     = seed_valid & seed_ready;
  assign load       = accept & (seed != '0);
  // Any handshake, even a rejected zero seed, freezes the state.
  assign adv        = (fsm_q == ST_RUN) & en & ~accept;

  // FSM, use counter and error pulse next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    err_d = accept & (seed == '0);
    if (load) begin
      fsm_d = ST_RUN;
      cnt_d = '0;
    end else if (adv && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_UNSEEDED;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  dom_rnd_lfsr_core #(
    .N_RND (N_RND)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .adv   (adv),
    .seed  (seed),
    .state (state),
    .rnd   (rnd)
  );

  assign rnd_valid  = (fsm_q == ST_RUN);
  assign reseed_req = (cnt_q == CNT_MAX);
  assign seed_err   = err_q;

endmodule

// File: tb/tb_dom_rnd_prng.sv
// Directed bench for dom_rnd_prng: three instances (d=2, d=3,
// d=2 with a short reseed period) share one stimulus stream.
module tb_dom_rnd_prng;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed;
  logic        seed_valid;
  logic        en;

  logic       rdy_a, val_a, req_a, err_a;
  logic [0:0] rnd_a;
  logic       rdy_b, val_b, req_b, err_b;
  logic [2:0] rnd_b;
  logic       rdy_c, val_c, req_c, err_c;
  logic [0:0] rnd_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dom_rnd_prng #(.d(2), .RESEED_PERIOD(1024)) u_a (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(rdy_a), .en(en), .rnd(rnd_a), .rnd_valid(val_a),
    .reseed_req(req_a), .seed_err(err_a)
  );

  dom_rnd_prng #(.d(3), .RESEED_PERIOD(1024)) u_b (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(rdy_b), .en(en), .rnd(rnd_b), .rnd_valid(val_b),
    .reseed_req(req_b), .seed_err(err_b)
  );

  dom_rnd_prng #(.d(2), .RESEED_PERIOD(4)) u_c (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(rdy_c), .en(en), .rnd(rnd_c), .rnd_valid(val_c),
    .reseed_req(req_c), .seed_err(err_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    seed = '0;
    seed_valid = 1'b0;
    en = 1'b0;

    #3;
    chk("rst_ready", 32'(rdy_a), 32'h0);
    chk("rst_valid", 32'(val_a), 32'h0);
    chk("rst_rnd", 32'(rnd_b), 32'h0);
    chk("rst_req", 32'(req_c), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(rdy_a), 32'h1);
    chk("idle_valid", 32'(val_a), 32'h0);
    chk("idle_req", 32'(req_a), 32'h0);

    en = 1'b1;
    tick(); tick();
    chk("unseeded_state", u_a.u_core.state_q, 32'h0);
    chk("unseeded_rnd", 32'(rnd_b), 32'h0);
    chk("unseeded_valid", 32'(val_b), 32'h0);
    en = 1'b0;

    seed = 32'h0; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("zero_err", 32'(err_a), 32'h1);
    chk("zero_valid", 32'(val_a), 32'h0);
    tick();
    chk("zero_err_clr", 32'(err_a), 32'h0);

    seed = 32'h1; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("load_state", u_a.u_core.state_q, 32'h1);
    chk("load_rnd", 32'(rnd_a), 32'h1);
    chk("load_valid", 32'(val_a), 32'h1);
    chk("load_rnd3", 32'(rnd_b), 32'h1);

    en = 1'b1;
    tick();
    chk("step1_state", u_a.u_core.state_q, 32'h3);
    chk("step1_rnd", 32'(rnd_a), 32'h1);
    chk("d3_state", u_b.u_core.state_q, 32'h0000_000D);
    chk("d3_rnd", 32'(rnd_b), 32'h5);

    en = 1'b0;
    tick();
    chk("hold_rnd3", 32'(rnd_b), 32'h5);
    chk("hold_state", u_a.u_core.state_q, 32'h3);

    en = 1'b1;
    tick();
    chk("step2_state", u_a.u_core.state_q, 32'h6);
    chk("step2_rnd", 32'(rnd_a), 32'h0);
    en = 1'b0;

    seed = 32'h0; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("run_zero_state", u_a.u_core.state_q, 32'h6);
    chk("run_zero_err", 32'(err_a), 32'h1);
    chk("run_zero_valid", 32'(val_a), 32'h1);

    en = 1'b1;
    tick();
    chk("step3_state", u_a.u_core.state_q, 32'hD);
    chk("step3_rnd", 32'(rnd_a), 32'h1);
    chk("req_before", 32'(req_c), 32'h0);

    tick();
    chk("step4_state", u_c.u_core.state_q, 32'h1B);
    chk("req_rise", 32'(req_c), 32'h1);

    tick();
    chk("req_run_state", u_c.u_core.state_q, 32'h36);
    chk("req_hold", 32'(req_c), 32'h1);
    chk("req_run_rnd", 32'(rnd_c), 32'h0);

    seed = 32'hDEAD_BEEF; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("reseed_state", u_c.u_core.state_q, 32'hDEAD_BEEF);
    chk("reseed_req", 32'(req_c), 32'h0);
    chk("reseed_cnt", 32'(u_c.cnt_q), 32'h0);
    chk("reseed_rnd3", 32'(rnd_b), 32'h7);

    tick();
    chk("beef_step", u_a.u_core.state_q, 32'hBD5B_7DDE);
    chk("beef_cnt", 32'(u_c.cnt_q), 32'h1);

    repeat (5) tick();
    chk("sat_cnt", 32'(u_c.cnt_q), 32'h4);
    chk("sat_req", 32'(req_c), 32'h1);

    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(val_c), 32'h0);
    chk("async_req", 32'(req_c), 32'h0);
    chk("async_rnd", 32'(rnd_b), 32'h0);
    chk("async_state", u_a.u_core.state_q, 32'h0);

    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_valid", 32'(val_a), 32'h0);
    chk("post_rst_state", u_a.u_core.state_q, 32'h0);

    seed = 32'h5; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    en = 1'b0;
    chk("reload_state", u_a.u_core.state_q, 32'h5);
    chk("reload_valid", 32'(val_a), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
